// File: rtl/csr_irq_unit.sv
// csr_irq_unit: machine-mode CSR file, WFI sleep/wake, trap entry and MRET return.
// Define CSR_COUNTERS_EN to implement the 64-bit mcycle/minstret counters.
module csr_irq_unit #(
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
    parameter int unsigned XLEN      = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_csr_valid,
    input  logic [2:0]      i_csr_funct3,
    input  logic [11:0]     i_csr_addr,
    input  logic [XLEN-1:0] i_csr_wdata,
    input  logic            i_csr_src_zero,
    output logic [XLEN-1:0] o_csr_rdata_c,
    input  logic            i_wfi,
    input  logic            i_mret,
    input  logic [XLEN-1:0] i_ex_pc,
    input  logic            i_ext_irq,
    input  logic            i_timer_irq,
    input  logic            i_retire,
    output logic            o_wfi_stall_c,
    output logic            o_redirect,
    output logic [XLEN-1:0] o_redirect_pc
);
    localparam int unsigned PC_W = XLEN - 2;

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MIP      = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_SLEEP = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_mie;
    logic            r_mpie;
    logic            r_meie;
    logic            r_mtie;
    logic [PC_W-1:0] r_mtvec;
    logic [PC_W-1:0] r_mepc;
    logic [PC_W-1:0] r_wfi_pc;
    logic            r_redirect;
    logic [XLEN-1:0] r_redirect_pc;

    logic            w_pend;
    logic            w_wr_req;
    logic            w_csr_we;
    logic            w_trap;
    logic            w_mret_go;
    logic            w_wfi_enter;
    logic [PC_W-1:0] w_trap_epc;
    logic [XLEN-1:0] w_csr_old;
    logic [XLEN-1:0] w_csr_new;

`ifdef CSR_COUNTERS_EN
    logic [63:0]     r_mcycle;
    logic [63:0]     r_minstret;
`endif

    assign w_pend   = (r_meie & i_ext_irq) | (r_mtie & i_timer_irq);
    // RS/RC forms with a zero source are pure reads
    assign w_wr_req = (i_csr_funct3[1:0] != 2'b00) && !(i_csr_funct3[1] && i_csr_src_zero);

    // CSR read mux; unimplemented addresses read as zero
    always_comb begin
        w_csr_old = '0;
        case (i_csr_addr)
            ADDR_MSTATUS: w_csr_old = {19'b0, 2'b11, 3'b0, r_mpie, 3'b0, r_mie, 3'b0};
            ADDR_MIE:     w_csr_old = {20'b0, r_meie, 3'b0, r_mtie, 7'b0};
            ADDR_MTVEC:   w_csr_old = {r_mtvec, 2'b00};
            ADDR_MEPC:    w_csr_old = {r_mepc, 2'b00};
            ADDR_MIP:     w_csr_old = {20'b0, i_ext_irq, 3'b0, i_timer_irq, 7'b0};
`ifdef CSR_COUNTERS_EN
            ADDR_MCYCLE:    w_csr_old = r_mcycle[31:0];
            ADDR_MCYCLEH:   w_csr_old = r_mcycle[63:32];
            ADDR_MINSTRET:  w_csr_old = r_minstret[31:0];
            ADDR_MINSTRETH: w_csr_old = r_minstret[63:32];
`endif
            default:      w_csr_old = '0;
        endcase
    end

    assign o_csr_rdata_c = w_csr_old;

    always_comb begin
        w_csr_new = w_csr_old;
        case (i_csr_funct3[1:0])
            2'b01:   w_csr_new = i_csr_wdata;
            2'b10:   w_csr_new = w_csr_old | i_csr_wdata;
            2'b11:   w_csr_new = w_csr_old & ~i_csr_wdata;
            default: w_csr_new = w_csr_old;
        endcase
    end

    // Next-state and action decode; the cycle after a redirect carries a flushed instruction
    always_comb begin
        w_state_nxt   = r_state;
        w_trap        = 1'b0;
        w_mret_go     = 1'b0;
        w_csr_we      = 1'b0;
        w_wfi_enter   = 1'b0;
        w_trap_epc    = i_ex_pc[XLEN-1:2];
        o_wfi_stall_c = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (!r_redirect) begin
                    if (w_pend && r_mie) begin
                        w_trap = 1'b1;
                    end else if (i_mret) begin
                        w_mret_go = 1'b1;
                    end else if (i_wfi) begin
                        if (!w_pend) begin
                            w_state_nxt = ST_SLEEP;
                            w_wfi_enter = 1'b1;
                        end
                    end else if (i_csr_valid) begin
                        w_csr_we = w_wr_req;
                    end
                end
            end
            ST_SLEEP: begin
                o_wfi_stall_c = !w_pend;
                w_trap_epc    = r_wfi_pc + PC_W'(1);
                if (w_pend) begin
                    w_state_nxt = ST_RUN;
                    w_trap      = r_mie;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_RUN;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mie         <= 1'b0;
            r_mpie        <= 1'b0;
            r_meie        <= 1'b0;
            r_mtie        <= 1'b0;
            r_mtvec       <= MTVEC_RST[XLEN-1:2];
            r_mepc        <= '0;
            r_wfi_pc      <= '0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
        end else begin
            r_redirect <= w_trap | w_mret_go;
            if (w_trap)         r_redirect_pc <= {r_mtvec, 2'b00};
            else if (w_mret_go) r_redirect_pc <= {r_mepc, 2'b00};
            if (w_wfi_enter) r_wfi_pc <= i_ex_pc[XLEN-1:2];
            if (w_trap) begin
                r_mepc <= w_trap_epc;
                r_mpie <= r_mie;
                r_mie  <= 1'b0;
            end else if (w_mret_go) begin
                r_mie  <= r_mpie;
                r_mpie <= 1'b1;
            end else if (w_csr_we) begin
                case (i_csr_addr)
                    ADDR_MSTATUS: begin
                        r_mie  <= w_csr_new[3];
                        r_mpie <= w_csr_new[7];
                    end
                    ADDR_MIE: begin
                        r_mtie <= w_csr_new[7];
                        r_meie <= w_csr_new[11];
                    end
                    ADDR_MTVEC: r_mtvec <= w_csr_new[XLEN-1:2];
                    ADDR_MEPC:  r_mepc  <= w_csr_new[XLEN-1:2];
                    default: ;
                endcase
            end
        end
    end

    assign o_redirect    = r_redirect;
    assign o_redirect_pc = r_redirect_pc;

`ifdef CSR_COUNTERS_EN
    // A CSR write to either half replaces the increment for that cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcycle   <= '0;
            r_minstret <= '0;
        end else begin
            if (w_csr_we && i_csr_addr == ADDR_MCYCLE)
                r_mcycle <= {r_mcycle[63:32], w_csr_new};
            else if (w_csr_we && i_csr_addr == ADDR_MCYCLEH)
                r_mcycle <= {w_csr_new, r_mcycle[31:0]};
            else
                r_mcycle <= r_mcycle + 64'd1;

            if (w_csr_we && i_csr_addr == ADDR_MINSTRET)
                r_minstret <= {r_minstret[63:32], w_csr_new};
            else if (w_csr_we && i_csr_addr == ADDR_MINSTRETH)
                r_minstret <= {w_csr_new, r_minstret[31:0]};
            else
                r_minstret <= r_minstret + 64'(i_retire);
        end
    end

    logic w_unused;
    assign w_unused = ^{i_csr_funct3[2], w_csr_new, i_ex_pc[1:0]};
`else
    logic w_unused;
    assign w_unused = ^{i_csr_funct3[2], w_csr_new, i_ex_pc[1:0], i_retire};
`endif

endmodule

// File: tb/tb_csr_irq_unit.sv
// tb_csr_irq_unit: directed self-checking bench for csr_irq_unit.
// Counter checks follow CSR_COUNTERS_EN.
module tb_csr_irq_unit;
    localparam logic [2:0] F_RW  = 3'b001;
    localparam logic [2:0] F_RS  = 3'b010;
    localparam logic [2:0] F_RC  = 3'b011;
    localparam logic [2:0] F_RWI = 3'b101;
    localparam logic [2:0] F_RSI = 3'b110;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_csr_valid;
    logic [2:0]  i_csr_funct3;
    logic [11:0] i_csr_addr;
    logic [31:0] i_csr_wdata;
    logic        i_csr_src_zero;
    logic [31:0] o_csr_rdata_c;
    logic        i_wfi;
    logic        i_mret;
    logic [31:0] i_ex_pc;
    logic        i_ext_irq;
    logic        i_timer_irq;
    logic        i_retire;
    logic        o_wfi_stall_c;
    logic        o_redirect;
    logic [31:0] o_redirect_pc;

    int n_tests = 0;
    int n_fail  = 0;

    csr_irq_unit #(.MTVEC_RST(32'h0000_0000), .XLEN(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_csr_valid    (i_csr_valid),
        .i_csr_funct3   (i_csr_funct3),
        .i_csr_addr     (i_csr_addr),
        .i_csr_wdata    (i_csr_wdata),
        .i_csr_src_zero (i_csr_src_zero),
        .o_csr_rdata_c  (o_csr_rdata_c),
        .i_wfi          (i_wfi),
        .i_mret         (i_mret),
        .i_ex_pc        (i_ex_pc),
        .i_ext_irq      (i_ext_irq),
        .i_timer_irq    (i_timer_irq),
        .i_retire       (i_retire),
        .o_wfi_stall_c  (o_wfi_stall_c),
        .o_redirect     (o_redirect),
        .o_redirect_pc  (o_redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [11:0] addr, input string tag, input logic [31:0] exp);
        i_csr_addr = addr;
        #1;
        check(tag, o_csr_rdata_c, exp);
    endtask

    task automatic csr(input logic [2:0] f3, input logic [11:0] addr,
                       input logic [31:0] wdata, input logic sz);
        i_csr_valid    = 1'b1;
        i_csr_funct3   = f3;
        i_csr_addr     = addr;
        i_csr_wdata    = wdata;
        i_csr_src_zero = sz;
        step();
        i_csr_valid    = 1'b0;
        i_csr_src_zero = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        i_csr_valid = 1'b0; i_csr_funct3 = 3'b000; i_csr_addr = 12'h000;
        i_csr_wdata = '0; i_csr_src_zero = 1'b0; i_wfi = 1'b0; i_mret = 1'b0;
        i_ex_pc = '0; i_ext_irq = 1'b0; i_timer_irq = 1'b0; i_retire = 1'b0;
        repeat (3) step();
        rst = 1'b0;

        // reset state
        check("rst_redirect", 32'(o_redirect), 32'd0);
        check("rst_redirect_pc", o_redirect_pc, 32'h0);
        check("rst_stall", 32'(o_wfi_stall_c), 32'd0);
        rd(12'h300, "rst_mstatus", 32'h0000_1800);
        rd(12'h304, "rst_mie", 32'h0);
        rd(12'h341, "rst_mepc", 32'h0);
        rd(12'h305, "rst_mtvec", 32'h0);

        // mtvec RW/RS/RC, low bits cleared, zero-source RS is read-only
        csr(F_RW, 12'h305, 32'h8000_0107, 1'b0);
        rd(12'h305, "mtvec_rw", 32'h8000_0104);
        i_csr_valid = 1'b1; i_csr_funct3 = F_RS; i_csr_addr = 12'h305;
        i_csr_wdata = 32'hFFFF_FFFF; i_csr_src_zero = 1'b1;
        #1 check("rs_old_rdata", o_csr_rdata_c, 32'h8000_0104);
        step();
        i_csr_valid = 1'b0; i_csr_src_zero = 1'b0;
        rd(12'h305, "mtvec_rs_zero", 32'h8000_0104);
        csr(F_RC, 12'h305, 32'h8000_0000, 1'b0);
        rd(12'h305, "mtvec_rc", 32'h0000_0104);
        csr(F_RS, 12'h305, 32'h8000_0000, 1'b0);
        rd(12'h305, "mtvec_rs", 32'h8000_0104);

        // mip read-only, unimplemented address, mstatus fixed bits
        i_timer_irq = 1'b1;
        csr(F_RW, 12'h344, 32'hFFFF_FFFF, 1'b0);
        rd(12'h344, "mip_ro", 32'h0000_0080);
        i_timer_irq = 1'b0;
        csr(F_RW, 12'h123, 32'hDEAD_BEEF, 1'b0);
        rd(12'h123, "unimpl", 32'h0);
        csr(F_RW, 12'h300, 32'hFFFF_FFFF, 1'b0);
        rd(12'h300, "mstatus_all", 32'h0000_1888);
        csr(F_RC, 12'h300, 32'h0000_0088, 1'b0);
        rd(12'h300, "mstatus_rc", 32'h0000_1800);

        // external interrupt trap squashes the EX CSR write
        csr(F_RWI, 12'h304, 32'h0000_0800, 1'b0);
        rd(12'h304, "mie_meie", 32'h0000_0800);
        csr(F_RSI, 12'h300, 32'h0000_0008, 1'b0);
        rd(12'h300, "mstatus_mie", 32'h0000_1808);
        i_ext_irq = 1'b1; i_ex_pc = 32'h200;
        i_csr_valid = 1'b1; i_csr_funct3 = F_RW; i_csr_addr = 12'h305; i_csr_wdata = 32'h0;
        step();
        i_csr_valid = 1'b0; i_ext_irq = 1'b0;
        check("trap_redirect", 32'(o_redirect), 32'd1);
        check("trap_pc", o_redirect_pc, 32'h8000_0104);
        rd(12'h341, "trap_mepc", 32'h200);
        rd(12'h300, "trap_mstatus", 32'h0000_1880);
        rd(12'h305, "trap_squash", 32'h8000_0104);
        step();
        check("trap_pulse", 32'(o_redirect), 32'd0);

        // mret
        i_mret = 1'b1; i_ex_pc = 32'h204;
        step();
        i_mret = 1'b0;
        check("mret_redirect", 32'(o_redirect), 32'd1);
        check("mret_pc", o_redirect_pc, 32'h200);
        rd(12'h300, "mret_mstatus", 32'h0000_1888);
        step();
        check("mret_pulse", 32'(o_redirect), 32'd0);

        // WFI with MIE=0: wake without redirect
        csr(F_RC, 12'h300, 32'h0000_0008, 1'b0);
        csr(F_RW, 12'h304, 32'h0000_0080, 1'b0);
        i_wfi = 1'b1; i_ex_pc = 32'h300;
        step();
        i_wfi = 1'b0;
        check("wfi_stall", 32'(o_wfi_stall_c), 32'd1);
        repeat (4) step();
        check("wfi_stall_hold", 32'(o_wfi_stall_c), 32'd1);
        i_timer_irq = 1'b1;
        #1 check("wfi_wake_comb", 32'(o_wfi_stall_c), 32'd0);
        step();
        check("wake_noredir", 32'(o_redirect), 32'd0);
        check("wake_stall", 32'(o_wfi_stall_c), 32'd0);
        rd(12'h341, "wake_mepc", 32'h200);
        i_timer_irq = 1'b0;

        // WFI with MIE=1: wake traps to mtvec with mepc = wfi_pc+4
        csr(F_RS, 12'h300, 32'h0000_0008, 1'b0);
        i_wfi = 1'b1; i_ex_pc = 32'h300;
        step();
        i_wfi = 1'b0;
        check("wfi2_stall", 32'(o_wfi_stall_c), 32'd1);
        repeat (4) step();
        i_timer_irq = 1'b1;
        #1 check("wfi2_wake_comb", 32'(o_wfi_stall_c), 32'd0);
        step();
        i_timer_irq = 1'b0;
        check("wfi2_redirect", 32'(o_redirect), 32'd1);
        check("wfi2_pc", o_redirect_pc, 32'h8000_0104);
        rd(12'h341, "wfi2_mepc", 32'h304);
        rd(12'h300, "wfi2_mstatus", 32'h0000_1880);
        step();
        check("wfi2_pulse", 32'(o_redirect), 32'd0);

        // WFI with interrupt already pending (MIE=0) is a NOP
        i_timer_irq = 1'b1; i_wfi = 1'b1; i_ex_pc = 32'h400;
        step();
        i_wfi = 1'b0; i_timer_irq = 1'b0;
        #1 check("wfi_nop_stall", 32'(o_wfi_stall_c), 32'd0);
        check("wfi_nop_redir", 32'(o_redirect), 32'd0);

        // trap wins over a simultaneous mret
        csr(F_RS, 12'h300, 32'h0000_0008, 1'b0);
        csr(F_RS, 12'h304, 32'h0000_0800, 1'b0);
        rd(12'h304, "mie_both", 32'h0000_0880);
        i_mret = 1'b1; i_ext_irq = 1'b1; i_ex_pc = 32'h500;
        step();
        i_mret = 1'b0; i_ext_irq = 1'b0;
        check("prio_redirect", 32'(o_redirect), 32'd1);
        check("prio_pc", o_redirect_pc, 32'h8000_0104);
        rd(12'h341, "prio_mepc", 32'h500);
        rd(12'h300, "prio_mstatus", 32'h0000_1880);
        step();

        // interrupt arriving in the mret redirect cycle is deferred one cycle
        i_mret = 1'b1; i_ex_pc = 32'h600;
        step();
        i_mret = 1'b0;
        check("b2b_first", 32'(o_redirect), 32'd1);
        check("b2b_first_pc", o_redirect_pc, 32'h500);
        i_ext_irq = 1'b1;
        step();
        check("b2b_gap", 32'(o_redirect), 32'd0);
        step();
        i_ext_irq = 1'b0;
        check("b2b_second", 32'(o_redirect), 32'd1);
        check("b2b_second_pc", o_redirect_pc, 32'h8000_0104);
        rd(12'h341, "b2b_mepc", 32'h600);
        step();

        // counters
`ifdef CSR_COUNTERS_EN
        csr(F_RW, 12'hB00, 32'hFFFF_FFFF, 1'b0);
        csr(F_RW, 12'hB80, 32'h0, 1'b0);
        step();
        rd(12'hB80, "mcycleh_carry", 32'h1);
        rd(12'hB00, "mcycle_wrap", 32'h0);
        i_retire = 1'b1;
        csr(F_RW, 12'hB02, 32'h10, 1'b0);
        repeat (3) step();
        i_retire = 1'b0;
        rd(12'hB02, "minstret", 32'h13);
        rd(12'hB82, "minstreth", 32'h0);
`else
        csr(F_RW, 12'hB00, 32'h5, 1'b0);
        rd(12'hB00, "mcycle_off", 32'h0);
        rd(12'hB80, "mcycleh_off", 32'h0);
        rd(12'hB02, "minstret_off", 32'h0);
        rd(12'hB82, "minstreth_off", 32'h0);
`endif

        // reset during a redirect
        i_mret = 1'b1; i_ex_pc = 32'h700;
        step();
        i_mret = 1'b0;
        check("rr_redirect", 32'(o_redirect), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rr_redirect_clr", 32'(o_redirect), 32'd0);
        check("rr_pc_clr", o_redirect_pc, 32'h0);
        rd(12'h300, "rr_mstatus", 32'h0000_1800);

        // reset during SLEEP
        i_wfi = 1'b1; i_ex_pc = 32'h800;
        step();
        i_wfi = 1'b0;
        check("rs_stall", 32'(o_wfi_stall_c), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1 check("rs_stall_clr", 32'(o_wfi_stall_c), 32'd0);
        rd(12'h305, "rs_mtvec", 32'h0);
        rd(12'h341, "rs_mepc", 32'h0);
        step();
        check("rs_run", 32'(o_wfi_stall_c), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
